// File: rtl/mem_if_pkg.sv
// Shared types and constants for the LC-3 SRAM bus responder.
package mem_if_pkg;

    localparam int unsigned DATA_W          = 16;
    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        WR1,
        WR2,
        HOLD
    } state_t;

endpackage

// File: rtl/sram_array.sv
// Single-port RAM with a synchronous, resettable read register and per-byte write enables.
module sram_array
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter string       INIT_FILE = ""
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W/8-1:0]   we_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < DATA_W / 8; b++) begin
            if (we_i[b]) begin
                mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the LC-3 SRAM bus: two-cycle strobe FSM, on-chip RAM, one I/O word.
module sram_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [15:0] IO_ADDR   = IO_ADDR_DEFAULT,
    parameter string       INIT_FILE = ""
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_CE,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic              Mem_UB,
    input  logic              Mem_LB,
    input  logic [15:0]       Addr,
    input  logic [15:0]       Data_to_mem,
    output logic [15:0]       Data_from_mem,
    input  logic [15:0]       Switches,
    output logic [15:0]       Hex_out,
    output logic              Access_done
);

    state_t state_q, state_d;

    logic [15:0]       addr_q;
    logic [15:0]       wdata_q;
    logic              ub_q, lb_q;
    logic              op_wr_q;
    logic              rd_io_q;
    logic [15:0]       sw_q;
    logic [15:0]       hex_q, hex_d;

    logic              io_hit;
    logic              rd_fire;
    logic              wr_latch;
    logic              commit;
    logic              ram_rd_en;
    logic [1:0]        ram_we;
    logic [15:0]       ram_rdata;

    assign io_hit = (addr_q == IO_ADDR);

    always_comb begin
        state_d  = state_q;
        rd_fire  = 1'b0;
        wr_latch = 1'b0;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!Mem_CE && !Mem_WE) begin
                    state_d = WR1;
                end else if (!Mem_CE && !Mem_OE) begin
                    state_d = RD1;
                end
            end
            RD1: begin
                if (Mem_CE || Mem_OE || !Mem_WE) begin
                    state_d = IDLE;
                end else begin
                    state_d = RD2;
                    rd_fire = 1'b1;
                end
            end
            RD2: begin
                state_d = !Mem_OE ? HOLD : IDLE;
            end
            WR1: begin
                if (Mem_CE || Mem_WE) begin
                    state_d = IDLE;
                end else begin
                    state_d  = WR2;
                    wr_latch = 1'b1;
                end
            end
            WR2: begin
                commit  = !Mem_CE && !Mem_WE;
                state_d = !Mem_WE ? HOLD : IDLE;
            end
            HOLD: begin
                if (Mem_CE || (op_wr_q ? Mem_WE : Mem_OE)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hex_d     = hex_q;
        ram_rd_en = rd_fire && !io_hit;
        ram_we    = '0;
        // A commit on the reset edge is dropped, for both RAM and the I/O register.
        if (commit && !Reset) begin
            if (io_hit) begin
                if (!ub_q) hex_d[15:8] = wdata_q[15:8];
                if (!lb_q) hex_d[7:0]  = wdata_q[7:0];
            end else begin
                ram_we = {~ub_q, ~lb_q};
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            hex_q   <= '0;
            rd_io_q <= 1'b0;
            sw_q    <= '0;
        end else begin
            state_q <= state_d;
            hex_q   <= hex_d;
            if (rd_fire) begin
                rd_io_q <= io_hit;
                if (io_hit) sw_q <= Switches;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (state_q == IDLE) begin
            addr_q  <= Addr;
            op_wr_q <= !Mem_WE;
        end
        if (wr_latch) begin
            wdata_q <= Data_to_mem;
            ub_q    <= Mem_UB;
            lb_q    <= Mem_LB;
        end
    end

    sram_array #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .rd_en_i (ram_rd_en),
        .addr_i  (addr_q[ADDR_W-1:0]),
        .we_i    (ram_we),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // Both sources are registers, so the read value stays stable until the next read.
    assign Data_from_mem = rd_io_q ? sw_q : ram_rdata;
    assign Hex_out       = hex_q;
    assign Access_done   = (state_q == RD2) || (state_q == WR2);

endmodule
